// File: rtl/spi_ctrl.sv
// SPI initiator: accepts bytes on a valid/ready stream and shifts them MSB-first in any CPOL/CPHA mode.
// Latency: acceptance to rx_valid is 17*CLK_DIV+1 Clk cycles; a tx_last byte returns tx_ready after 18*CLK_DIV.
// Backpressure: tx_ready is high only in IDLE/WAIT, and tx_valid is ignored elsewhere; rx_valid is a pulse that cannot be stalled.
module spi_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    input  logic       SPI_CPOL,
    input  logic       SPI_CPHA,
    output logic       SPI_clk,
    output logic       SPI_csb,
    output logic       SPI_copi,
    input  logic       SPI_cipo
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, GAP} state_t;

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] div_cnt;
    logic       tick;
    logic [3:0] edge_cnt;   // SPI_clk edges already produced in this byte
    logic       shift_end;  // high for the single cycle after the 16th edge
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic       last_q;
    logic       cpol_q;
    logic       cpha_q;
    logic       accept;

    assign tick   = (div_cnt == DIV_MAX);
    assign accept = tx_valid && tx_ready;

    // Half-period divider; parked at zero while waiting for a byte so SETUP always lasts a full tick
    always_ff @(posedge Clk) begin
        if (Rst || state == IDLE || state == WAIT || tick) begin
            div_cnt <= 8'd0;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = SETUP;
            SETUP:   if (tick)      state_nxt = SHIFT;
            SHIFT:   if (shift_end) state_nxt = last_q ? GAP : WAIT;
            WAIT:    if (accept)    state_nxt = SETUP;
            GAP:     if (tick)      state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Stream-side outputs decoded from the state
    always_comb begin
        tx_ready = 1'b0;
        busy     = 1'b0;
        if (!Rst) begin
            tx_ready = (state == IDLE) || (state == WAIT);
            busy     = (state != IDLE);
        end
    end

    // Serial datapath: byte/mode latching, edge generation, drive and sample
    always_ff @(posedge Clk) begin
        if (Rst) begin
            SPI_csb   <= 1'b1;
            SPI_clk   <= SPI_CPOL;
            SPI_copi  <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            edge_cnt  <= 4'd0;
            shift_end <= 1'b0;
            tx_sr     <= 8'h00;
            rx_sr     <= 8'h00;
            last_q    <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            shift_end <= 1'b0;
            case (state)
                IDLE: begin
                    SPI_clk <= SPI_CPOL;
                    SPI_csb <= 1'b1;
                    if (accept) begin
                        tx_sr    <= tx_data;
                        last_q   <= tx_last;
                        cpol_q   <= SPI_CPOL;
                        cpha_q   <= SPI_CPHA;
                        SPI_csb  <= 1'b0;
                        SPI_copi <= tx_data[7];
                    end
                end
                SETUP: begin
                    edge_cnt <= 4'd0;
                end
                SHIFT: begin
                    if (shift_end) begin
                        rx_data  <= rx_sr;
                        rx_valid <= 1'b1;
                        if (last_q) begin
                            SPI_csb <= 1'b1;
                        end
                    end else if (tick) begin
                        SPI_clk  <= ~SPI_clk;
                        edge_cnt <= edge_cnt + 4'd1;
                        if (edge_cnt == 4'd15) begin
                            shift_end <= 1'b1;
                        end
                        if (edge_cnt[0] == 1'b0) begin
                            // leading edge
                            if (cpha_q) begin
                                SPI_copi <= tx_sr[7];
                                tx_sr    <= {tx_sr[6:0], 1'b0};
                            end else begin
                                rx_sr <= {rx_sr[6:0], SPI_cipo};
                            end
                        end else begin
                            // trailing edge; mode-0/2 bit 7 went out before the first edge
                            if (cpha_q) begin
                                rx_sr <= {rx_sr[6:0], SPI_cipo};
                            end else if (edge_cnt != 4'd15) begin
                                SPI_copi <= tx_sr[6];
                                tx_sr    <= {tx_sr[6:0], 1'b0};
                            end
                        end
                    end
                end
                WAIT: begin
                    SPI_clk <= cpol_q;
                    SPI_csb <= 1'b0;
                    if (accept) begin
                        tx_sr    <= tx_data;
                        last_q   <= tx_last;
                        SPI_copi <= tx_data[7];
                    end
                end
                GAP: begin
                    SPI_clk <= cpol_q;
                    SPI_csb <= 1'b1;
                end
                default: begin
                    SPI_csb <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ctrl.sv
// Directed bench for spi_ctrl: loopback vector table across all modes plus hand-written corner sequences.
// Latency: expected timing derived from CLK_DIV (rx_valid at 17*D+1, tx_ready at 18*D or 17*D+1 when chained).
// Backpressure: bytes are offered only when tx_ready is seen; every wait is cycle-bounded.
module tb_spi_ctrl;

    localparam int D  = 4;
    localparam int D2 = 2;

    logic       Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Rst;
    logic [7:0] tx_data;
    logic       tx_valid, tx_last, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, busy;
    logic       cpol, cpha, sclk, csb, copi, cipo;
    logic       loop_en, p_cipo;

    assign cipo = loop_en ? copi : p_cipo;

    spi_ctrl #(.CLK_DIV(D)) dut (
        .Clk(Clk), .Rst(Rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .SPI_CPOL(cpol), .SPI_CPHA(cpha),
        .SPI_clk(sclk), .SPI_csb(csb), .SPI_copi(copi), .SPI_cipo(cipo)
    );

    logic [7:0] tx2_data, rx2_data;
    logic       tx2_valid, tx2_last, tx2_ready, rx2_valid, busy2;
    logic       cpol2, cpha2, sclk2, csb2, copi2, cipo2;

    assign cipo2 = copi2;

    spi_ctrl #(.CLK_DIV(D2)) dut2 (
        .Clk(Clk), .Rst(Rst),
        .tx_data(tx2_data), .tx_valid(tx2_valid), .tx_last(tx2_last), .tx_ready(tx2_ready),
        .rx_data(rx2_data), .rx_valid(rx2_valid), .busy(busy2),
        .SPI_CPOL(cpol2), .SPI_CPHA(cpha2),
        .SPI_clk(sclk2), .SPI_csb(csb2), .SPI_copi(copi2), .SPI_cipo(cipo2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Peripheral receiver model, CPHA=1: drives on leading edges, samples on trailing edges
    logic [7:0] p_tx, p_out, p_in, p_byte, p_reg;
    int         p_bits, p_vld;
    logic       p_clk_q, p_csb_q;

    initial begin
        p_cipo = 1'b0; p_out = 8'h00; p_in = 8'h00; p_byte = 8'h00; p_reg = 8'h00;
        p_bits = 0; p_vld = 0; p_clk_q = 1'b0; p_csb_q = 1'b1;
    end

    always @(negedge Clk) begin
        if (csb === 1'b0 && p_csb_q === 1'b1) p_bits = 0;
        if (csb === 1'b1 && p_csb_q === 1'b0) begin
            p_reg = p_byte;
            p_vld++;
        end
        if (csb === 1'b0 && sclk !== p_clk_q) begin
            if (sclk != cpol) begin
                if (p_bits == 0) p_out = p_tx;
                p_cipo = p_out[7];
                p_out  = {p_out[6:0], 1'b0};
            end else begin
                p_in = {p_in[6:0], copi};
                p_bits++;
                if (p_bits == 8) begin
                    p_byte = p_in;
                    p_bits = 0;
                end
            end
        end
        p_clk_q = sclk;
        p_csb_q = csb;
    end

    // Per-byte observations gathered by send_byte
    int         r_edges, r_viol, r_rxv, r_rxv_at, r_ready_at, r_csb_low;
    logic [7:0] r_rx, r_cap;

    // Offer one byte to dut and observe it cycle by cycle until tx_ready returns
    task automatic send_byte(input logic [7:0] b, input logic last);
        logic pclk, pcopi, lead;
        int   w;
        r_edges = 0; r_viol = 0; r_rxv = 0; r_rxv_at = -1; r_ready_at = -1; r_csb_low = 0;
        r_rx = 8'h00; r_cap = 8'h00;
        w = 0;
        while (tx_ready !== 1'b1 && w < 100) begin
            @(negedge Clk);
            w++;
        end
        check("tx_ready_before_byte", tx_ready, 1'b1);
        tx_data = b; tx_last = last; tx_valid = 1'b1;
        pclk = sclk; pcopi = copi;
        @(posedge Clk);
        @(negedge Clk);
        tx_valid = 1'b0;
        for (int n = 0; n < 25 * D; n++) begin
            if (n > 0) @(negedge Clk);
            if (rx_valid === 1'b1) begin
                r_rxv++;
                r_rxv_at = n;
                r_rx = rx_data;
            end
            if (csb === 1'b0) r_csb_low++;
            if (sclk !== pclk) begin
                r_edges++;
                lead = (sclk != cpol);
                if (lead == !cpha) r_cap = {r_cap[6:0], copi};
            end
            if (n > 0 && copi !== pcopi) begin
                if (!(sclk !== pclk && (sclk != cpol) == cpha)) r_viol++;
            end
            pclk = sclk; pcopi = copi;
            if (n > 0 && tx_ready === 1'b1) begin
                r_ready_at = n;
                break;
            end
        end
    endtask

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic [7:0] tx;
        logic       last;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int         e, bad, rxv, v0, e2, rdy2;
        logic       pc, p2, fd;
        logic [7:0] cap2, rx2;

        vecs[0] = '{1'b0, 1'b0, 8'hA5, 1'b1, 8'hA5};
        vecs[1] = '{1'b0, 1'b1, 8'h81, 1'b1, 8'h81};
        vecs[2] = '{1'b1, 1'b0, 8'h81, 1'b1, 8'h81};
        vecs[3] = '{1'b1, 1'b1, 8'h3C, 1'b0, 8'h3C};
        vecs[4] = '{1'b1, 1'b1, 8'hC3, 1'b1, 8'hC3};
        vecs[5] = '{1'b0, 1'b0, 8'hFF, 1'b0, 8'hFF};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00};

        Rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; tx_last = 1'b0;
        cpol = 1'b0; cpha = 1'b0; loop_en = 1'b1; p_tx = 8'h00;
        tx2_data = 8'h00; tx2_valid = 1'b0; tx2_last = 1'b0; cpol2 = 1'b0; cpha2 = 1'b0;

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_csb", csb, 1'b1);
        check("rst_clk", sclk, 1'b0);
        check("rst_copi", copi, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_csb_div2", csb2, 1'b1);
        cpol = 1'b1;
        @(negedge Clk);
        check("rst_clk_follows_cpol", sclk, 1'b1);
        cpol = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check("idle_tx_ready", tx_ready, 1'b1);

        // Loopback vectors over all four modes
        foreach (vecs[i]) begin
            cpol = vecs[i].cpol;
            cpha = vecs[i].cpha;
            repeat (2) @(negedge Clk);
            check($sformatf("v%0d_clk_idle_pre", i), sclk, vecs[i].cpol);
            send_byte(vecs[i].tx, vecs[i].last);
            check($sformatf("v%0d_rx_data", i), r_rx, vecs[i].exp_rx);
            check($sformatf("v%0d_rx_pulses", i), r_rxv, 1);
            check($sformatf("v%0d_rx_at", i), r_rxv_at, 17 * D + 1);
            check($sformatf("v%0d_edges", i), r_edges, 16);
            check($sformatf("v%0d_copi_bits", i), r_cap, vecs[i].tx);
            check($sformatf("v%0d_drive_edge_viol", i), r_viol, 0);
            check($sformatf("v%0d_ready_at", i), r_ready_at, vecs[i].last ? 18 * D : 17 * D + 1);
            check($sformatf("v%0d_csb_low", i), r_csb_low, vecs[i].last ? 17 * D + 1 : 17 * D + 2);
            check($sformatf("v%0d_busy_end", i), busy, !vecs[i].last);
            @(negedge Clk);
            check($sformatf("v%0d_clk_idle_post", i), sclk, vecs[i].cpol);
        end

        // Mode 3 against the peripheral model: chained 0x3C, 0xC3
        loop_en = 1'b0; cpol = 1'b1; cpha = 1'b1; p_tx = 8'h5A;
        repeat (2) @(negedge Clk);
        v0 = p_vld;
        send_byte(8'h3C, 1'b0);
        check("m3_rx_first", r_rx, 8'h5A);
        check("m3_csb_held", csb, 1'b0);
        check("m3_no_deselect", p_vld - v0, 0);
        send_byte(8'hC3, 1'b1);
        check("m3_rx_second", r_rx, 8'h5A);
        repeat (2) @(negedge Clk);
        check("m3_periph_pulses", p_vld - v0, 1);
        check("m3_periph_reg", p_reg, 8'hC3);
        loop_en = 1'b1;

        // Chained frame with the second byte delayed 50 cycles
        cpol = 1'b0; cpha = 1'b0;
        repeat (2) @(negedge Clk);
        send_byte(8'h96, 1'b0);
        check("wait_rx_first", r_rx, 8'h96);
        bad = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge Clk);
            if (csb !== 1'b0 || sclk !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b1) bad++;
        end
        check("wait_hold_cycles_bad", bad, 0);
        send_byte(8'h69, 1'b1);
        check("wait_rx_second", r_rx, 8'h69);
        check("wait_copi_second", r_cap, 8'h69);
        check("wait_ready_second", r_ready_at, 18 * D);

        // Reset at edge 7 of a byte
        repeat (2) @(negedge Clk);
        tx_data = 8'h3C; tx_last = 1'b1; tx_valid = 1'b1;
        pc = sclk;
        @(posedge Clk);
        @(negedge Clk);
        tx_valid = 1'b0;
        e = 0;
        for (int n = 0; n < 20 * D && e < 7; n++) begin
            if (n > 0) @(negedge Clk);
            if (sclk !== pc) e++;
            pc = sclk;
        end
        check("rstmid_edges_reached", e, 7);
        Rst = 1'b1;
        @(negedge Clk);
        check("rstmid_csb", csb, 1'b1);
        check("rstmid_clk", sclk, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_rx_valid", rx_valid, 1'b0);
        @(negedge Clk);
        Rst = 1'b0;
        rxv = 0;
        for (int n = 0; n < 20 * D; n++) begin
            @(negedge Clk);
            if (rx_valid === 1'b1) rxv++;
        end
        check("rstmid_no_rx_valid", rxv, 0);
        send_byte(8'hFF, 1'b1);
        check("rstmid_next_rx", r_rx, 8'hFF);
        check("rstmid_next_ready", r_ready_at, 18 * D);

        // CLK_DIV=2 with SPI_CPOL toggled mid-frame
        @(negedge Clk);
        check("div2_tx_ready", tx2_ready, 1'b1);
        tx2_data = 8'h5A; tx2_last = 1'b1; tx2_valid = 1'b1;
        p2 = sclk2;
        @(posedge Clk);
        @(negedge Clk);
        tx2_valid = 1'b0;
        e2 = 0; cap2 = 8'h00; rx2 = 8'h00; rdy2 = -1; fd = 1'b0;
        for (int n = 0; n < 30 * D2; n++) begin
            if (n > 0) @(negedge Clk);
            if (n == 5) cpol2 = 1'b1;
            if (sclk2 !== p2) begin
                e2++;
                if (e2 == 1) fd = sclk2;
                if (sclk2 === 1'b1) cap2 = {cap2[6:0], copi2};
            end
            p2 = sclk2;
            if (rx2_valid === 1'b1) rx2 = rx2_data;
            if (n > 0 && tx2_ready === 1'b1) begin
                rdy2 = n;
                break;
            end
        end
        check("div2_edges", e2, 16);
        check("div2_first_edge_rising", fd, 1'b1);
        check("div2_copi_bits", cap2, 8'h5A);
        check("div2_rx", rx2, 8'h5A);
        check("div2_ready_at", rdy2, 18 * D2);
        check("div2_clk_old_cpol_at_idle", sclk2, 1'b0);
        @(negedge Clk);
        check("div2_clk_new_cpol", sclk2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
